// File: rtl/life_array_reader.sv
// Frame readout engine for the 4x4 life array: snapshots alive/alive_prev on start,
// then streams one 4-bit row per valid/ready transfer and reports frame statistics.
module life_array_reader #(
    parameter int GEN_W      = 16,
    parameter int SKIP_EMPTY = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [15:0]      alive,
    input  logic [15:0]      alive_prev,
    output logic [3:0]       row_data,
    output logic [1:0]       row_idx,
    output logic             row_valid,
    input  logic             row_ready,
    output logic             row_first,
    output logic             row_last,
    output logic             busy,
    output logic             done,
    output logic             changed,
    output logic [4:0]       alive_count,
    output logic [GEN_W-1:0] gen_count,
    output logic [1:0]       dbg_state_o
);

    // Row handshake: a row moves at a rising edge where row_valid && row_ready;
    // while row_ready is low the presented row (data, idx, first, last) is held.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      snap_q, snap_d;
    logic [15:0]      snap_prev_q, snap_prev_d;
    logic [1:0]       row_idx_q, row_idx_d;
    logic             row_valid_q, row_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             changed_q, changed_d;
    logic [4:0]       count_q, count_d;
    logic [GEN_W-1:0] gen_q, gen_d;

    function automatic logic [4:0] popcount(input logic [15:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < 16; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        snap_prev_d = snap_prev_q;
        row_idx_d   = row_idx_q;
        row_valid_d = row_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        changed_d   = changed_q;
        count_d     = count_q;
        gen_d       = gen_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    snap_d      = alive;
                    snap_prev_d = alive_prev;
                    changed_d   = (alive != alive_prev);
                    count_d     = popcount(alive);
                    row_idx_d   = 2'd0;
                    busy_d      = 1'b1;
                    if (SKIP_EMPTY != 0 && alive == 16'd0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        gen_d   = gen_q + GEN_W'(1);
                    end else begin
                        state_d     = S_SEND;
                        row_valid_d = 1'b1;
                    end
                end
            end
            S_SEND: begin
                if (row_ready) begin
                    if (row_idx_q == 2'd3) begin
                        state_d     = S_DONE;
                        row_valid_d = 1'b0;
                        done_d      = 1'b1;
                        gen_d       = gen_q + GEN_W'(1);
                    end else begin
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d     = S_IDLE;
                row_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            snap_q      <= 16'd0;
            snap_prev_q <= 16'd0;
            row_idx_q   <= 2'd0;
            row_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            changed_q   <= 1'b0;
            count_q     <= 5'd0;
            gen_q       <= '0;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            snap_prev_q <= snap_prev_d;
            row_idx_q   <= row_idx_d;
            row_valid_q <= row_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            changed_q   <= changed_d;
            count_q     <= count_d;
            gen_q       <= gen_d;
        end
    end

    // Payload always comes from the captured snapshot, never from the live array.
    assign row_data    = snap_q[{row_idx_q, 2'b00} +: 4];
    assign row_idx     = row_idx_q;
    assign row_valid   = row_valid_q;
    assign row_first   = row_valid_q && (row_idx_q == 2'd0);
    assign row_last    = row_valid_q && (row_idx_q == 2'd3);
    assign busy        = busy_q;
    assign done        = done_q;
    assign changed     = changed_q;
    assign alive_count = count_q;
    assign gen_count   = gen_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_life_array_reader.sv
// Directed bench for life_array_reader: a default instance, a SKIP_EMPTY=1 instance
// and a GEN_W=2 instance share clock, reset, array inputs and row_ready.
module tb_life_array_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, start_skip, start_w2;
    logic [15:0] alive, alive_prev;
    logic        row_ready;

    logic [3:0]  row_data, row_data_s, row_data_w;
    logic [1:0]  row_idx, row_idx_s, row_idx_w;
    logic        row_valid, row_valid_s, row_valid_w;
    logic        row_first, row_first_s, row_first_w;
    logic        row_last, row_last_s, row_last_w;
    logic        busy, busy_s, busy_w;
    logic        done, done_s, done_w;
    logic        changed, changed_s, changed_w;
    logic [4:0]  alive_count, alive_count_s, alive_count_w;
    logic [15:0] gen_count, gen_count_s;
    logic [1:0]  gen_count_w;
    logic [1:0]  dbg, dbg_s, dbg_w;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    life_array_reader #(.GEN_W(16), .SKIP_EMPTY(0)) dut (
        .clk(clk), .reset(reset), .start(start), .alive(alive), .alive_prev(alive_prev),
        .row_data(row_data), .row_idx(row_idx), .row_valid(row_valid), .row_ready(row_ready),
        .row_first(row_first), .row_last(row_last), .busy(busy), .done(done),
        .changed(changed), .alive_count(alive_count), .gen_count(gen_count), .dbg_state_o(dbg)
    );

    life_array_reader #(.GEN_W(16), .SKIP_EMPTY(1)) dut_skip (
        .clk(clk), .reset(reset), .start(start_skip), .alive(alive), .alive_prev(alive_prev),
        .row_data(row_data_s), .row_idx(row_idx_s), .row_valid(row_valid_s), .row_ready(row_ready),
        .row_first(row_first_s), .row_last(row_last_s), .busy(busy_s), .done(done_s),
        .changed(changed_s), .alive_count(alive_count_s), .gen_count(gen_count_s), .dbg_state_o(dbg_s)
    );

    life_array_reader #(.GEN_W(2), .SKIP_EMPTY(0)) dut_w2 (
        .clk(clk), .reset(reset), .start(start_w2), .alive(alive), .alive_prev(alive_prev),
        .row_data(row_data_w), .row_idx(row_idx_w), .row_valid(row_valid_w), .row_ready(row_ready),
        .row_first(row_first_w), .row_last(row_last_w), .busy(busy_w), .done(done_w),
        .changed(changed_w), .alive_count(alive_count_w), .gen_count(gen_count_w), .dbg_state_o(dbg_w)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench at the negedge of the cycle after the capture edge.
    task automatic pulse_start;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Walks a frame on the default instance from its first row through the return
    // to IDLE. Optional stall during stall_row; optional start pulse during start_row.
    task automatic expect_frame(input string tag, input logic [15:0] snap,
                                input int stall_row, input int stall_cycles,
                                input int start_row);
        logic [3:0] exp_row;
        for (int r = 0; r < 4; r++) begin
            exp_row = snap[4*r +: 4];
            check({tag, "_valid"}, row_valid, 1);
            check({tag, "_idx"}, row_idx, r);
            check({tag, "_data"}, row_data, exp_row);
            check({tag, "_first"}, row_first, r == 0);
            check({tag, "_last"}, row_last, r == 3);
            check({tag, "_nodone"}, done, 0);
            start = (r == start_row);
            if (r == stall_row) begin
                row_ready = 1'b0;
                for (int s = 0; s < stall_cycles; s++) begin
                    @(negedge clk);
                    start = 1'b0;
                    check({tag, "_stall_valid"}, row_valid, 1);
                    check({tag, "_stall_idx"}, row_idx, r);
                    check({tag, "_stall_data"}, row_data, exp_row);
                end
                row_ready = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_done_valid"}, row_valid, 0);
        check({tag, "_done_busy"}, busy, 1);
        @(negedge clk);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_done"}, done, 0);
    endtask

    initial begin
        int got;
        reset = 1'b1; start = 1'b0; start_skip = 1'b0; start_w2 = 1'b0;
        alive = 16'h0000; alive_prev = 16'h0000; row_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", row_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_gen", gen_count, 0);
        check("rst_count", alive_count, 0);
        check("rst_changed", changed, 0);
        check("rst_data", row_data, 0);
        check("rst_state", dbg, 0);
        reset = 1'b0;

        // Empty frame with SKIP_EMPTY=1: straight to done, no rows.
        @(negedge clk);
        start_skip = 1'b1;
        @(negedge clk);
        start_skip = 1'b0;
        check("skip_valid", row_valid_s, 0);
        check("skip_done", done_s, 1);
        check("skip_count", alive_count_s, 0);
        check("skip_gen", gen_count_s, 1);
        @(negedge clk);
        check("skip_idle_busy", busy_s, 0);
        check("skip_idle_valid", row_valid_s, 0);

        // Blinker.
        alive = 16'h0070; alive_prev = 16'h0222;
        pulse_start();
        check("blink_changed", changed, 1);
        check("blink_count", alive_count, 3);
        expect_frame("blink", 16'h0070, -1, 0, -1);
        check("blink_gen", gen_count, 1);

        // Beacon with a 3-cycle stall on row 1.
        alive = 16'hCC33; alive_prev = 16'hCC33;
        pulse_start();
        check("beacon_changed", changed, 0);
        check("beacon_count", alive_count, 8);
        expect_frame("beacon", 16'hCC33, 1, 3, -1);
        check("beacon_gen", gen_count, 2);

        // Snapshot isolation plus an ignored start while busy.
        alive = 16'h6996; alive_prev = 16'h0000;
        pulse_start();
        alive = 16'h0000;
        check("iso_changed", changed, 1);
        check("iso_count", alive_count, 8);
        expect_frame("iso", 16'h6996, -1, 0, 1);
        check("iso_gen", gen_count, 3);
        check("iso_no_restart", row_valid, 0);

        // Empty frame with SKIP_EMPTY=0 still sends four zero rows.
        alive = 16'h0000; alive_prev = 16'h0000;
        pulse_start();
        check("empty_count", alive_count, 0);
        expect_frame("empty", 16'h0000, -1, 0, -1);
        check("empty_gen", gen_count, 4);

        // gen_count wrap on the GEN_W=2 instance: 1, 2, 3, 0, 1.
        alive = 16'h8421;
        for (int f = 0; f < 5; f++) begin
            @(negedge clk);
            start_w2 = 1'b1;
            @(negedge clk);
            start_w2 = 1'b0;
            got = 0;
            for (int c = 0; c < 20 && got == 0; c++) begin
                if (done_w) got = 1;
                else @(negedge clk);
            end
            check("wrap_done_seen", got, 1);
            check("wrap_gen", gen_count_w, (f + 1) % 4);
        end
        @(negedge clk);

        // Reset during row 2 aborts the frame.
        alive = 16'hFFFF; alive_prev = 16'h0000;
        pulse_start();
        @(negedge clk);
        @(negedge clk);
        check("abort_pre_idx", row_idx, 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_valid", row_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_gen", gen_count, 0);
        check("abort_count", alive_count, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        check("abort_done_after", done, 0);
        alive = 16'h0001;
        pulse_start();
        expect_frame("post_rst", 16'h0001, -1, 0, -1);
        check("post_rst_gen", gen_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test expected finish");
        $fatal(1);
    end

endmodule

// File: doc/life_array_reader.md
Name: life_array_reader

Overview:
- Readout engine for the 4x4 life array: the reader side of the array's `val`/`write_enb` load path.
- On a `start` pulse it snapshots the array's `alive` and `alive_prev` vectors, then streams the snapshot out one 4-bit row per transfer over a valid/ready handshake.
- Also reports population count, a changed-since-previous-generation flag and a completed-frame counter.
- Sits between the array and a display or serial front end.

Parameters:
- GEN_W, 16, width of the completed-frame counter `gen_count`.
- SKIP_EMPTY, 0, when 1 an all-zero snapshot emits no rows and goes straight to done.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a frame readout; sampled only in IDLE
- alive  input  16  current generation from the array; bit 4*i+j = row i, column j
- alive_prev  input  16  previous generation from the array, same bit layout
- row_data  output  4  row payload; row_data[j] = snapshot[4*row_idx+j]
- row_idx  output  2  index of the row being presented, 0..3
- row_valid  output  1  row_data/row_idx are valid
- row_ready  input  1  sink accepts the row
- row_first  output  1  high with row_valid when row_idx==0
- row_last  output  1  high with row_valid when row_idx==3
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse at frame completion
- changed  output  1  snapshot of alive differs from snapshot of alive_prev; held until next capture
- alive_count  output  5  population count of the alive snapshot, 0..16; held until next capture
- gen_count  output  GEN_W  number of completed frames, wraps modulo 2^GEN_W

Behaviour:
- Reset values: state IDLE, all outputs 0, snapshots 0.
- Reset has priority over every other event. Reset mid-frame aborts the frame: no done pulse, gen_count cleared.
- State IDLE:
  - start high at edge k: capture snap=alive, snap_prev=alive_prev.
  - Load changed=(alive!=alive_prev) and alive_count=popcount(alive) in the same edge.
  - Set row_idx=0 and go to SEND.
  - Exception: if SKIP_EMPTY==1 and alive==0, go to DONE instead.
- State SEND:
  - row_valid=1; row_first/row_last decoded combinationally from row_idx.
  - Transfer occurs at an edge where row_valid && row_ready.
  - Transfer with row_idx<3: row_idx increments and the next row is presented on the following cycle (one row per cycle under continuous ready).
  - Transfer with row_idx==3: go to DONE; row_valid low the cycle after.
  - row_ready low: row_data, row_idx, row_first, row_last held stable, row_valid stays high. No timeout.
- State DONE (one cycle):
  - done=1, gen_count increments (wraps at all-ones to 0).
  - Next state IDLE; busy drops with the return to IDLE.
- start while busy is ignored, not queued. start asserted continuously re-captures in the IDLE cycle after each DONE.
- Latency:
  - start at edge k → first row valid in the cycle after edge k.
  - Full frame with ready held high: rows valid cycles k+1..k+4, done in cycle k+5, IDLE in cycle k+6.
- Snapshot isolation: alive/alive_prev changes after capture (step, write_enb) do not affect the frame in flight.
- row_data is taken from the snapshot, never directly from alive.

Test Plan:
- Blinker: alive=0x0070, alive_prev=0x0222, row_ready=1, pulse start.
  - Rows idx0..3 = 0x0, 0x7, 0x0, 0x0; row_first on idx0, row_last on idx3.
  - changed=1, alive_count=3, done one cycle after last row, gen_count=1.
- Beacon with backpressure: alive=0xCC33, alive_prev=0xCC33; row_ready low for 3 cycles during row 1.
  - Rows = 0x3, 0x3, 0xC, 0xC; row 1 held stable and valid while stalled.
  - changed=0, alive_count=8.
- Snapshot isolation and start-while-busy:
  - Capture alive=0x6996, then change alive to 0x0000 and pulse start during row 1.
  - Streamed rows remain 0x6, 0x9, 0x9, 0x6; exactly one done; gen_count increments by 1 only.
- Empty frame: alive=0x0000.
  - SKIP_EMPTY=0: four rows of 0x0 are sent.
  - SKIP_EMPTY=1: no row_valid, done in the cycle after start's capture edge, alive_count=0.
- Reset mid-frame: assert reset during row 2.
  - Next cycle row_valid=0, busy=0, gen_count=0, alive_count=0, no done pulse.
  - A subsequent start on alive=0x0001 streams 0x1, 0x0, 0x0, 0x0.
- gen_count wrap (GEN_W=2): run 5 frames → gen_count sequence 1, 2, 3, 0, 1.
